// File: rtl/ysyx_22041461_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, cause codes, mstatus fields,
// trap request encodings, trap sequencer states and the mstatus update rule.
package ysyx_22041461_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned CAUSE_ECALL_M = 11;
  localparam int unsigned CAUSE_ILLEGAL = 2;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Width the mstatus helper works on; callers with narrower XLEN cast in and out.
  localparam int MSTATUS_W = 64;

  typedef enum logic [1:0] {
    TRAP_NOP     = 2'b00,
    TRAP_ECALL   = 2'b01,
    TRAP_MRET    = 2'b10,
    TRAP_ILLEGAL = 2'b11
  } trap_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EPC_WR,
    ST_CAUSE_WR,
    ST_STAT_UPD,
    ST_VEC_RD,
    ST_EPC_RD,
    ST_REDIR
  } trap_state_e;

  // Trap entry stacks MIE into MPIE; mret unstacks it. MPP is pinned to M.
  function automatic logic [MSTATUS_W-1:0] mstatus_next(
    input logic [MSTATUS_W-1:0] rdata,
    input logic                 is_mret
  );
    logic [MSTATUS_W-1:0] r;
    r = rdata;
    if (is_mret) begin
      r[MSTATUS_MIE]  = rdata[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
    end else begin
      r[MSTATUS_MPIE] = rdata[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
    end
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22041461_trap_seq.sv
// Trap sequencer: walks the CSR file port through mepc/mcause/mstatus save or
// restore for ecall, illegal instruction and mret, then pulses a PC redirect.
module ysyx_22041461_trap_seq
  import ysyx_22041461_csr_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MTVEC_ALIGN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  output logic            trap_ready,
  input  logic [1:0]      trap_kind,
  input  logic [XLEN-1:0] trap_pc,
  output logic [11:0]     csr_addr,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] VEC_MASK = ~((XLEN'(1) << MTVEC_ALIGN) - XLEN'(1));

  trap_state_e     state_q, state_d;
  trap_kind_e      kind_q, kind_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] mstatus_upd;

  assign mstatus_upd = XLEN'(mstatus_next(MSTATUS_W'(csr_rdata), kind_q == TRAP_MRET));

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_valid) begin
          kind_d = trap_kind_e'(trap_kind);
          pc_d   = trap_pc;
          case (trap_kind_e'(trap_kind))
            TRAP_ECALL, TRAP_ILLEGAL: state_d = ST_EPC_WR;
            TRAP_MRET:                state_d = ST_STAT_UPD;
            default:                  state_d = ST_IDLE;
          endcase
        end
      end
      ST_EPC_WR:   state_d = ST_CAUSE_WR;
      ST_CAUSE_WR: state_d = ST_STAT_UPD;
      ST_STAT_UPD: state_d = (kind_q == TRAP_MRET) ? ST_EPC_RD : ST_VEC_RD;
      ST_VEC_RD: begin
        redirect_pc_d = csr_rdata & VEC_MASK;
        state_d       = ST_REDIR;
      end
      ST_EPC_RD: begin
        redirect_pc_d = csr_rdata;
        state_d       = ST_REDIR;
      end
      ST_REDIR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      kind_q        <= TRAP_NOP;
      pc_q          <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Port controls are masked by rst so an aborted sequence commits nothing
  // and redirects nowhere on the edge that resets it.
  always_comb begin
    csr_addr       = 12'h000;
    csr_wen        = 1'b0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_EPC_WR: begin
        csr_addr  = CSR_MEPC;
        csr_wen   = 1'b1;
        csr_wdata = pc_q;
      end
      ST_CAUSE_WR: begin
        csr_addr  = CSR_MCAUSE;
        csr_wen   = 1'b1;
        csr_wdata = (kind_q == TRAP_ILLEGAL) ? XLEN'(CAUSE_ILLEGAL) : XLEN'(CAUSE_ECALL_M);
      end
      ST_STAT_UPD: begin
        csr_addr  = CSR_MSTATUS;
        csr_wen   = 1'b1;
        csr_wdata = mstatus_upd;
      end
      ST_VEC_RD:   csr_addr = CSR_MTVEC;
      ST_EPC_RD:   csr_addr = CSR_MEPC;
      ST_REDIR:    redirect_valid = 1'b1;
      default:     ;
    endcase
    if (rst) begin
      csr_addr       = 12'h000;
      csr_wen        = 1'b0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
    end
  end

  assign trap_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign redirect_pc = redirect_pc_q;

endmodule
